mesh_wormhole_credit_node: RTL and testbench
============================================

# mesh_wormhole_credit_node

A five-port 2D-mesh wormhole router node with credit-based flow control. It replaces FIFO-full backpressure with per-output credit counters. Per-output arbitration is round-robin with a packet lock. Every output is registered. It sits at each mesh coordinate and connects to four neighbour nodes plus a local port. Routing is dimension-order XY.

## Interface
Parameters:
- FLIT_DATA_W, 8: payload bits per flit.
- FLIT_ID_W, 2: flit-type bits; flit is {id, data}, FLIT_W = FLIT_ID_W+FLIT_DATA_W.
- ROW_ADDR_W, 2: destination-row bits in the head payload.
- COL_ADDR_W, 2: destination-column bits in the head payload.
- ROW_CORD, 1: this node's row.
- COL_CORD, 1: this node's column.
- BUFFER_DEPTH, 4: flits per input buffer; also the initial credit per output; power of two, at least 2.

Ports (port index p: 0 local, 1 north, 2 east, 3 south, 4 west):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_chan_data_i  in  5*FLIT_W  incoming flits, port p at [p*FLIT_W +: FLIT_W]
- in_chan_vld_i  in  5  flit valid; upstream only asserts while it holds a credit
- in_chan_credit_o  out  5  one-cycle pulse per flit freed from input buffer p
- out_chan_data_o  out  5*FLIT_W  outgoing flits, registered
- out_chan_vld_o  out  5  outgoing flit valid, registered
- out_chan_credit_i  in  5  one-cycle credit return from the downstream node
- err_o  out  5  only with MESH_NODE_ERR_EN; sticky per-input error

## Operation
- Flit ids: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, HEAD_TAIL=2'b11.
- Head payload layout: column address in [COL_ADDR_W-1:0], row address in [COL_ADDR_W +: ROW_ADDR_W].
- Input buffer:
  - Writes on in_chan_vld_i with no ready signal.
  - When a HEAD or HEAD_TAIL flit reaches the front, it computes and latches an XY route:
    - dest col > COL_CORD → east; dest col < COL_CORD → west.
    - Otherwise dest row > ROW_CORD → south; dest row < ROW_CORD → north.
    - Otherwise local.
  - The route is held until a TAIL or HEAD_TAIL flit pops.
- Each output has a lock (idle/busy), an owner index, a round-robin pointer and a credit counter.
  - Counter width is $clog2(BUFFER_DEPTH+1); reset value is BUFFER_DEPTH.
- Idle output:
  - Candidates are inputs whose front flit is HEAD or HEAD_TAIL routed to this output.
  - Grant goes to the first candidate at or after the pointer, in cyclic order.
  - The grant happens only if credit > 0.
  - A HEAD grant locks the output to that input; a HEAD_TAIL grant does not.
- Busy output: forwards the owner's front flit whenever the buffer is non-empty and credit > 0.
- Sending a flit:
  - Pops the input buffer.
  - Registers the flit onto the output.
  - Decrements the credit counter.
  - Pulses in_chan_credit_o of the source input.
- Packet end: sending TAIL or HEAD_TAIL unlocks the output and sets the pointer to owner+1 mod 5.
- Each input pops at most once per cycle; its latched route names exactly one output, so there are no conflicts.
- Credit update in one cycle:
  - out_chan_credit_i alone increments the counter.
  - A send alone decrements it.
  - Both together leave it unchanged.
- A U-turn route (a flit routed back out its own input port) is legal; no restriction is applied.

## Timing
- Reset (asynchronous, rst_ni low):
  - All output and credit-out registers clear: out_chan_vld_o=0, out_chan_data_o=0, in_chan_credit_o=0.
  - All buffers become empty; all locks become idle; all pointers become 0.
  - Credit counters become BUFFER_DEPTH.
  - err_o=0.
- Reset asserted mid-packet discards all in-flight state. Upstream and downstream nodes share the reset.
- Latency:
  - Flit written in cycle 0 is at the buffer front in cycle 1.
  - It is sent (out_chan_vld_o=1) in cycle 2 if the output is granted and credit is available.
  - in_chan_credit_o pulses in cycle 2.
- Sustained throughput is one flit per cycle per output while credit > 0.
- With credit 0, no send occurs. A credit arriving in cycle k allows a send in cycle k+1 (out_chan_vld_o in cycle k+1).
- A new head can be granted in the cycle after the tail is sent; no bubble is required beyond that.

## Configuration
- MESH_NODE_ERR_EN defined:
  - err_o exists.
  - err_o[p] sets on a write while buffer p is full (that flit is dropped).
  - err_o[p] sets when a BODY or TAIL flit reaches an unrouted front (that flit is popped and discarded, with a credit returned).
  - err_o[p] clears only on reset.
- MESH_NODE_ERR_EN undefined: the err_o port is absent and behaviour on these conditions is undefined.

## Structure
- Package mesh_noc_pkg holds:
  - Flit id constants.
  - Port index constants (LOCAL, NORTH, EAST, SOUTH, WEST).
  - The FLIT_W function of the parameters.
- Sub-module mesh_wh_input_buffer contains the circular FIFO (BUFFER_DEPTH), the XY route latch and the credit pulse.
- Arbiters, credit counters, the crossbar mux and output registers live in the top.

## Test plan
- Node (1,1): HEAD_TAIL flit to (1,3) on local at cycle 0 → out_chan_vld_o[EAST]=1 at cycle 2 with identical data; in_chan_credit_o[0] pulses at cycle 2.
- Head/body/body/tail from west to (3,1) → four consecutive south flits in order.
- Same packet on north and east simultaneously to local, pointer 0 → north (index 1) packet sent completely first, then east; pointer ends at 3.
- Downstream returns no credits, 6-flit packet → exactly 4 flits sent, then stall; one out_chan_credit_i pulse → exactly one more flit the next cycle.
- Credit return and send in the same cycle → counter unchanged (check via sustained stream, no stall).
- rst_ni low mid-packet → outputs 0 immediately; after release a new head is routed normally. With MESH_NODE_ERR_EN, a lone BODY flit on input 2 → err_o=5'b00100.

Source files
------------

// File: rtl/mesh_noc_pkg.sv
// Shared definitions for the mesh wormhole router: flit ids, port indices,
// flit-width helper and the cyclic port increment used by the arbiters.
package mesh_noc_pkg;

  localparam logic [1:0] FLIT_HEAD      = 2'b10;
  localparam logic [1:0] FLIT_BODY      = 2'b00;
  localparam logic [1:0] FLIT_TAIL      = 2'b01;
  localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

  localparam int NUM_PORTS = 5;

  localparam logic [2:0] LOCAL = 3'd0;
  localparam logic [2:0] NORTH = 3'd1;
  localparam logic [2:0] EAST  = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] WEST  = 3'd4;

  function automatic int flit_w(input int id_w, input int data_w);
    return id_w + data_w;
  endfunction

  // Next port index in cyclic order 0..4
  function automatic logic [2:0] port_next(input logic [2:0] p);
    return (p == WEST) ? LOCAL : p + 3'd1;
  endfunction

endpackage

// File: rtl/mesh_wh_input_buffer.sv
// Per-input circular flit FIFO with XY route latch and credit-return pulse.
// Optional MESH_NODE_ERR_EN adds a sticky error flag for overflow writes and
// for BODY/TAIL flits that reach the front without a routed packet.
module mesh_wh_input_buffer
  import mesh_noc_pkg::*;
#(
  parameter int FLIT_DATA_W  = 8,
  parameter int FLIT_ID_W    = 2,
  parameter int ROW_ADDR_W   = 2,
  parameter int COL_ADDR_W   = 2,
  parameter int ROW_CORD     = 1,
  parameter int COL_CORD     = 1,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [FLIT_ID_W+FLIT_DATA_W-1:0]  wr_flit_i,
  input  logic                              wr_vld_i,
  input  logic                              pop_i,
  output logic [FLIT_ID_W+FLIT_DATA_W-1:0]  front_flit_o,
  output logic                              front_vld_o,
  output logic                              front_head_o,
  output logic                              front_end_o,
  output logic [2:0]                        route_o,
  output logic                              credit_o
`ifdef MESH_NODE_ERR_EN
  ,
  output logic                              err_o
`endif
);

  localparam int FLIT_W = flit_w(FLIT_ID_W, FLIT_DATA_W);
  localparam int PTR_W  = $clog2(BUFFER_DEPTH);
  localparam int ADDR_W = ROW_ADDR_W + COL_ADDR_W;
  localparam logic [FLIT_ID_W-1:0] ID_HEAD      = FLIT_ID_W'(FLIT_HEAD);
  localparam logic [FLIT_ID_W-1:0] ID_BODY      = FLIT_ID_W'(FLIT_BODY);
  localparam logic [FLIT_ID_W-1:0] ID_TAIL      = FLIT_ID_W'(FLIT_TAIL);
  localparam logic [FLIT_ID_W-1:0] ID_HEAD_TAIL = FLIT_ID_W'(FLIT_HEAD_TAIL);

  logic [FLIT_W-1:0]    mem_q [BUFFER_DEPTH];
  logic [FLIT_W-1:0]    mem_d [BUFFER_DEPTH];
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 routed_q, routed_d, credit_q, credit_d;
  logic [2:0]           route_q, route_d, xy;
  logic [FLIT_ID_W-1:0] front_id;
  logic                 empty, full, is_head, is_end, stray, pop_eff, wr_en;

  // Dimension-order routing: resolve column first, then row
  function automatic logic [2:0] xy_route(input logic [ADDR_W-1:0] addr);
    logic [COL_ADDR_W-1:0] dc;
    logic [ROW_ADDR_W-1:0] dr;
    dc = addr[COL_ADDR_W-1:0];
    dr = addr[COL_ADDR_W +: ROW_ADDR_W];
    if (dc > COL_ADDR_W'(COL_CORD))      return EAST;
    else if (dc < COL_ADDR_W'(COL_CORD)) return WEST;
    else if (dr > ROW_ADDR_W'(ROW_CORD)) return SOUTH;
    else if (dr < ROW_ADDR_W'(ROW_CORD)) return NORTH;
    else                                 return LOCAL;
  endfunction

  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign front_flit_o = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign front_id     = front_flit_o[FLIT_W-1 -: FLIT_ID_W];
  assign is_head      = (front_id == ID_HEAD) || (front_id == ID_HEAD_TAIL);
  assign is_end       = (front_id == ID_TAIL) || (front_id == ID_HEAD_TAIL);
  assign xy           = xy_route(front_flit_o[ADDR_W-1:0]);
  // A body/tail with no packet in progress can never be forwarded; drain it
  assign stray        = !empty && !routed_q &&
                        ((front_id == ID_BODY) || (front_id == ID_TAIL));
  assign front_vld_o  = !empty && !stray;
  assign front_head_o = is_head;
  assign front_end_o  = is_end;
  assign route_o      = is_head ? xy : route_q;
  assign pop_eff      = (pop_i && front_vld_o) || stray;
  assign wr_en        = wr_vld_i && !full;
  assign credit_o     = credit_q;

  // Next-state for FIFO pointers, storage, route latch and credit pulse
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    routed_d = routed_q;
    route_d  = route_q;
    credit_d = pop_eff;
    if (wr_en) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = wr_flit_i;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_eff) rd_ptr_d = rd_ptr_q + 1'b1;
    if (!empty && is_head) begin
      routed_d = 1'b1;
      route_d  = xy;
    end
    if (pop_eff && is_end) routed_d = 1'b0;
  end

  // Flit storage carries data only, so it is not reset
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      routed_q <= 1'b0;
      route_q  <= LOCAL;
      credit_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      routed_q <= routed_d;
      route_q  <= route_d;
      credit_q <= credit_d;
    end
  end

`ifdef MESH_NODE_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q | (wr_vld_i && full) | stray;
  assign err_o = err_q;

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`endif

endmodule

// File: rtl/mesh_wormhole_credit_node.sv
// Five-port XY wormhole router node with per-output credit counters,
// round-robin arbitration with packet lock and registered outputs.
// Optional MESH_NODE_ERR_EN exposes the per-input sticky err_o port.
module mesh_wormhole_credit_node
  import mesh_noc_pkg::*;
#(
  parameter int FLIT_DATA_W  = 8,
  parameter int FLIT_ID_W    = 2,
  parameter int ROW_ADDR_W   = 2,
  parameter int COL_ADDR_W   = 2,
  parameter int ROW_CORD     = 1,
  parameter int COL_CORD     = 1,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [5*(FLIT_ID_W+FLIT_DATA_W)-1:0] in_chan_data_i,
  input  logic [4:0]                          in_chan_vld_i,
  output logic [4:0]                          in_chan_credit_o,
  output logic [5*(FLIT_ID_W+FLIT_DATA_W)-1:0] out_chan_data_o,
  output logic [4:0]                          out_chan_vld_o,
  input  logic [4:0]                          out_chan_credit_i
`ifdef MESH_NODE_ERR_EN
  ,
  output logic [4:0]                          err_o
`endif
);

  localparam int FLIT_W = flit_w(FLIT_ID_W, FLIT_DATA_W);
  localparam int CNT_W  = $clog2(BUFFER_DEPTH + 1);

  logic [FLIT_W-1:0] front_flit [NUM_PORTS];
  logic [2:0]        route      [NUM_PORTS];
  logic [4:0]        front_vld, front_head, front_end, pop, send;
  logic [2:0]        src        [NUM_PORTS];
  logic [4:0]        lock_q, lock_d, out_vld_q, out_vld_d;
  logic [2:0]        owner_q [NUM_PORTS];
  logic [2:0]        owner_d [NUM_PORTS];
  logic [2:0]        rr_q    [NUM_PORTS];
  logic [2:0]        rr_d    [NUM_PORTS];
  logic [CNT_W-1:0]  cnt_q   [NUM_PORTS];
  logic [CNT_W-1:0]  cnt_d   [NUM_PORTS];
  logic [FLIT_W-1:0] out_data_q [NUM_PORTS];
  logic [FLIT_W-1:0] out_data_d [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    mesh_wh_input_buffer #(
      .FLIT_DATA_W (FLIT_DATA_W),
      .FLIT_ID_W   (FLIT_ID_W),
      .ROW_ADDR_W  (ROW_ADDR_W),
      .COL_ADDR_W  (COL_ADDR_W),
      .ROW_CORD    (ROW_CORD),
      .COL_CORD    (COL_CORD),
      .BUFFER_DEPTH(BUFFER_DEPTH)
    ) u_ibuf (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .wr_flit_i   (in_chan_data_i[p*FLIT_W +: FLIT_W]),
      .wr_vld_i    (in_chan_vld_i[p]),
      .pop_i       (pop[p]),
      .front_flit_o(front_flit[p]),
      .front_vld_o (front_vld[p]),
      .front_head_o(front_head[p]),
      .front_end_o (front_end[p]),
      .route_o     (route[p]),
      .credit_o    (in_chan_credit_o[p])
`ifdef MESH_NODE_ERR_EN
      ,
      .err_o       (err_o[p])
`endif
    );

    assign out_chan_data_o[p*FLIT_W +: FLIT_W] = out_data_q[p];
  end

  assign out_chan_vld_o = out_vld_q;

  // Per-output arbitration, crossbar select, lock and credit bookkeeping
  always_comb begin
    logic [2:0] idx;
    logic       found;
    logic       avail;
    pop        = '0;
    send       = '0;
    lock_d     = lock_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      src[o] = owner_q[o];
      idx    = rr_q[o];
      found  = 1'b0;
      // A credit arriving this cycle can be spent immediately
      avail  = (cnt_q[o] != '0) || out_chan_credit_i[o];
      if (lock_q[o]) begin
        send[o] = front_vld[owner_q[o]] && avail;
      end else begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          if (!found && front_vld[idx] && front_head[idx] && (route[idx] == 3'(o))) begin
            found  = 1'b1;
            src[o] = idx;
          end
          idx = port_next(idx);
        end
        send[o] = found && avail;
        if (send[o] && !front_end[src[o]]) begin
          lock_d[o]  = 1'b1;
          owner_d[o] = src[o];
        end
      end
      if (send[o]) begin
        pop[src[o]]   = 1'b1;
        out_data_d[o] = front_flit[src[o]];
        if (front_end[src[o]]) begin
          lock_d[o] = 1'b0;
          rr_d[o]   = port_next(src[o]);
        end
      end
      cnt_d[o] = cnt_q[o] + CNT_W'(out_chan_credit_i[o]) - CNT_W'(send[o]);
    end
    out_vld_d = send;
  end

  // Registered outputs and per-output arbitration state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= '0;
      out_vld_q <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        owner_q[o]    <= LOCAL;
        rr_q[o]       <= LOCAL;
        cnt_q[o]      <= CNT_W'(BUFFER_DEPTH);
        out_data_q[o] <= '0;
      end
    end else begin
      lock_q     <= lock_d;
      out_vld_q  <= out_vld_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_mesh_wormhole_credit_node.sv
// Directed bench for mesh_wormhole_credit_node at node (1,1).
// Build with MESH_NODE_ERR_EN defined to also cover the err_o port.
module tb_mesh_wormhole_credit_node;

  localparam int FW = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [5*FW-1:0] in_data;
  logic [4:0]      in_vld;
  logic [4:0]      in_credit;
  logic [5*FW-1:0] out_data;
  logic [4:0]      out_vld;
  logic [4:0]      out_credit;
  logic [4:0]      man_credit;
  logic            echo_en;
`ifdef MESH_NODE_ERR_EN
  logic [4:0]      err;
`endif

  int total = 0;
  int bad   = 0;

  logic [9:0] p2  [4];
  logic [9:0] p3n [3];
  logic [9:0] p3e [3];
  logic [9:0] e3  [6];
  logic [4:0] c3  [6];
  logic [9:0] p4  [6];
  logic [9:0] p5  [8];

  always #5 clk = ~clk;

  // Downstream model: echo a credit for every flit seen, or manual pulses
  assign out_credit = echo_en ? out_vld : man_credit;

  mesh_wormhole_credit_node dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .in_chan_data_i   (in_data),
    .in_chan_vld_i    (in_vld),
    .in_chan_credit_o (in_credit),
    .out_chan_data_o  (out_data),
    .out_chan_vld_o   (out_vld),
    .out_chan_credit_i(out_credit)
`ifdef MESH_NODE_ERR_EN
    ,
    .err_o            (err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int p, input logic [9:0] f);
    in_data[p*FW +: FW] = f;
    in_vld[p] = 1'b1;
  endtask

  task automatic clr_in();
    in_vld  = '0;
    in_data = '0;
  endtask

  function automatic logic [9:0] odata(input int p);
    return out_data[p*FW +: FW];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    p2  = '{10'h20D, 10'h011, 10'h022, 10'h133};
    p3n = '{10'h205, 10'h0AA, 10'h1BB};
    p3e = '{10'h205, 10'h0CC, 10'h1DD};
    e3  = '{10'h205, 10'h0AA, 10'h1BB, 10'h205, 10'h0CC, 10'h1DD};
    c3  = '{5'b00010, 5'b00010, 5'b00010, 5'b00100, 5'b00100, 5'b00100};
    p4  = '{10'h207, 10'h001, 10'h002, 10'h003, 10'h004, 10'h105};
    p5  = '{10'h207, 10'h010, 10'h011, 10'h012, 10'h013, 10'h014, 10'h015, 10'h1FF};

    rst_n = 1'b0; in_vld = '0; in_data = '0; echo_en = 1'b1; man_credit = '0;
    tick(); tick();
    check("rst_out_vld", out_vld, 5'b0);
    check("rst_out_data", out_data, '0);
    check("rst_in_credit", in_credit, 5'b0);
`ifdef MESH_NODE_ERR_EN
    check("rst_err", err, 5'b0);
`endif
    rst_n = 1'b1;
    tick();

    // Local HEAD_TAIL to (1,3): east output two cycles later
    set_in(0, 10'h3A7);
    tick(); clr_in();
    check("t1_c1_vld", out_vld, 5'b0);
    tick();
    check("t1_c2_vld", out_vld, 5'b00100);
    check("t1_c2_data", odata(2), 10'h3A7);
    check("t1_c2_credit", in_credit, 5'b00001);
    tick();
    check("t1_c3_vld", out_vld, 5'b0);
    check("t1_c3_credit", in_credit, 5'b0);

    // West packet to (3,1): four consecutive south flits
    for (int c = 0; c < 5; c++) begin
      clr_in();
      if (c < 4) set_in(4, p2[c]);
      tick();
      if (c + 1 >= 2) begin
        check("t2_vld", out_vld, 5'b01000);
        check("t2_data", odata(3), p2[c-1]);
      end
    end
    clr_in();
    tick();
    check("t2_end_vld", out_vld, 5'b0);

    // North and east contend for local: north whole packet first
    for (int c = 0; c < 7; c++) begin
      clr_in();
      if (c < 3) begin
        set_in(1, p3n[c]);
        set_in(2, p3e[c]);
      end
      tick();
      if (c + 1 >= 2) begin
        check("t3_vld", out_vld, 5'b00001);
        check("t3_data", odata(0), e3[c-1]);
        check("t3_credit", in_credit, c3[c-1]);
      end
    end
    tick();
    check("t3_end_vld", out_vld, 5'b0);

    // Local pointer now 3: west wins over north
    set_in(1, 10'h305);
    set_in(4, 10'h345);
    tick(); clr_in();
    tick();
    check("t3_rr_first", odata(0), 10'h345);
    check("t3_rr_first_vld", out_vld, 5'b00001);
    tick();
    check("t3_rr_second", odata(0), 10'h305);
    check("t3_rr_second_vld", out_vld, 5'b00001);
    tick();

    // No credit return: exactly four flits, then stall
    echo_en = 1'b0;
    for (int c = 0; c < 7; c++) begin
      clr_in();
      if (c < 6) set_in(0, p4[c]);
      tick();
      if (c + 1 >= 2 && c + 1 <= 5) begin
        check("t4_vld", out_vld, 5'b00100);
        check("t4_data", odata(2), p4[c-1]);
      end else if (c + 1 > 5) begin
        check("t4_stall_vld", out_vld, 5'b0);
      end
    end
    man_credit = 5'b00100;
    tick(); man_credit = '0;
    check("t4_one_vld", out_vld, 5'b00100);
    check("t4_one_data", odata(2), p4[4]);
    tick();
    check("t4_stall2_vld", out_vld, 5'b0);
    man_credit = 5'b00100;
    tick(); man_credit = '0;
    check("t4_tail_data", odata(2), p4[5]);
    check("t4_tail_vld", out_vld, 5'b00100);
    man_credit = 5'b00100;
    repeat (4) tick();
    man_credit = '0;
    check("t4_restore_vld", out_vld, 5'b0);
    echo_en = 1'b1;
    tick();

    // Sustained 8-flit stream: simultaneous return and send keep credit
    for (int c = 0; c < 9; c++) begin
      clr_in();
      if (c < 8) set_in(0, p5[c]);
      tick();
      if (c + 1 >= 2) begin
        check("t5_vld", out_vld, 5'b00100);
        check("t5_data", odata(2), p5[c-1]);
      end
    end
    clr_in();
    tick();
    check("t5_end_vld", out_vld, 5'b0);

    // Reset mid-packet, then a fresh head routes normally
    set_in(0, 10'h207);
    tick(); clr_in(); set_in(0, 10'h055);
    tick(); clr_in();
    check("t6_pre_vld", out_vld, 5'b00100);
    rst_n = 1'b0;
    #1;
    check("t6_rst_vld", out_vld, 5'b0);
    check("t6_rst_data", out_data, '0);
    check("t6_rst_credit", in_credit, 5'b0);
    tick();
    rst_n = 1'b1;
    tick();
    set_in(4, 10'h345);
    set_in(0, 10'h3A7);
    tick(); clr_in();
    tick();
    check("t6_post_vld", out_vld, 5'b00101);
    check("t6_post_local", odata(0), 10'h345);
    check("t6_post_east", odata(2), 10'h3A7);
    tick();

`ifdef MESH_NODE_ERR_EN
    // Lone BODY on east input flags an error and is discarded
    check("t7_err_clear", err, 5'b0);
    set_in(2, 10'h011);
    tick(); clr_in();
    tick(); tick();
    check("t7_err", err, 5'b00100);
    check("t7_no_out", out_vld, 5'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
